// File: rtl/case_conv_sched.sv
// Two-channel string-granular round-robin scheduler sharing one toUpper converter.
// Define CASE_CONV_COUNT_EN to add the per-channel saturating conversion counters.

module case_conv_to_upper (
  input  logic [7:0] data,
  input  logic       upper,
  output logic [7:0] data_c,
  output logic       changed_c
);
  assign changed_c = upper && (data >= 8'h61) && (data <= 8'h7A);
  assign data_c    = changed_c ? (data & 8'hDF) : data;
endmodule

module case_conv_sched #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned MAX_LEN = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c0_valid,
  output logic             c0_ready,
  input  logic [7:0]       c0_data,
  input  logic             c0_upper,
  input  logic             c1_valid,
  output logic             c1_ready,
  input  logic [7:0]       c1_data,
  input  logic             c1_upper,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [7:0]       o_data,
  output logic             o_src,
  output logic             o_last
`ifdef CASE_CONV_COUNT_EN
  ,
  output logic [CNT_W-1:0] conv_cnt0,
  output logic [CNT_W-1:0] conv_cnt1
`endif
);

  localparam int unsigned LEN_W = 8;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t             state_q, state_d;
  logic               rr_q, rr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               grant;
  logic               load_ok;
  logic               acc;
  logic               terminal;
  logic [7:0]         sel_data;
  logic               sel_upper;
  logic [7:0]         conv_data;
  logic               changed;

  assign load_ok   = !o_valid || o_ready;
  assign c0_ready  = load_ok && !grant && !rst;
  assign c1_ready  = load_ok &&  grant && !rst;
  assign acc       = grant ? (c1_valid && c1_ready) : (c0_valid && c0_ready);
  assign sel_data  = grant ? c1_data  : c0_data;
  assign sel_upper = grant ? c1_upper : c0_upper;
  assign terminal  = (sel_data == 8'h00) ||
                     ((9'(len_q) + 9'd1) == 9'(MAX_LEN));

  case_conv_to_upper u_to_upper (
    .data      (sel_data),
    .upper     (sel_upper),
    .data_c    (conv_data),
    .changed_c (changed)
  );

  // Grant: locked to the owner mid-string, otherwise the lone requester or rr.
  always_comb begin
    grant = rr_q;
    case (state_q)
      IDLE: begin
        if (c0_valid && !c1_valid)      grant = 1'b0;
        else if (c1_valid && !c0_valid) grant = 1'b1;
      end
      OWN0:    grant = 1'b0;
      OWN1:    grant = 1'b1;
      default: grant = rr_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    len_d   = len_q;
    if (acc) begin
      if (terminal) begin
        state_d = IDLE;
        rr_d    = !grant;
        len_d   = '0;
      end else begin
        len_d = len_q + LEN_W'(1);
        if (state_q == IDLE) state_d = grant ? OWN1 : OWN0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      len_q   <= len_d;
    end
  end

  // Single output stage; holds while the sink stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data  <= 8'h00;
      o_src   <= 1'b0;
      o_last  <= 1'b0;
    end else if (acc) begin
      o_valid <= 1'b1;
      o_data  <= conv_data;
      o_src   <= grant;
      o_last  <= terminal;
    end else if (o_ready) begin
      o_valid <= 1'b0;
    end
  end

`ifdef CASE_CONV_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_cnt0 <= '0;
      conv_cnt1 <= '0;
    end else if (acc && changed) begin
      if (!grant && (conv_cnt0 != '1)) conv_cnt0 <= conv_cnt0 + CNT_W'(1);
      if ( grant && (conv_cnt1 != '1)) conv_cnt1 <= conv_cnt1 + CNT_W'(1);
    end
  end
`else
  logic unused_count;
  assign unused_count = changed & (CNT_W != 0);
`endif

endmodule
